mips_bus_master: RTL and testbench
==================================

# mips_bus_master

Avalon-MM initiator that sits between the MIPS CPU datapath and the memory bus, turning one load or store request (byte, halfword or word; signed or unsigned) into a single Avalon read or write transaction. It word-aligns the bus address, generates byteenable, steers write data onto the correct byte lanes, and extracts and extends read data. It honours waitrequest stalls, rejects misaligned accesses without touching the bus, and returns a one-cycle completion pulse to the CPU control FSM.

## Interface
Parameters: none; all widths fixed at 32-bit address and data.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  synchronous, active-low (0 = reset).
- start  in  1  request strobe; sampled only in IDLE.
- op_write  in  1  1 = store, 0 = load.
- op_size  in  2  00 byte, 01 halfword, 10 word; 11 treated as misaligned (error).
- op_signed  in  1  loads only: 1 sign-extends, 0 zero-extends.
- op_addr  in  32  byte address.
- op_wdata  in  32  store data; the value occupies the low bits.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = misaligned or illegal size, no bus access made.
- rdata  out  32  extended load result; valid with done; held until next done.
- address  out  32  {op_addr[31:2], 2'b00}.
- read  out  1  Avalon read.
- write  out  1  Avalon write.
- byteenable  out  4  lane enables; bit k = byte offset k = bits 8k+7:8k.
- writedata  out  32  lane-steered store data.
- waitrequest  in  1  responder stall.
- readdata  in  32  responder data, valid when read=1 and waitrequest=0.

## Operation
- States: IDLE, ACCESS, FINISH.
- IDLE: when start=1, latch op_* and decode alignment.
  - Aligned: go to ACCESS.
  - Misaligned: go to FINISH with err=1. Misaligned means halfword with addr[0]=1, word with addr[1:0]≠0, or size 11.
- ACCESS: assert read or write. Hold address, byteenable and writedata stable while waitrequest=1.
  - When waitrequest=0, the transfer completes in that cycle. For loads, capture readdata in the same cycle.
  - Then go to FINISH.
- FINISH: done=1 for one cycle, then return to IDLE.
- Byteenable rules:
  - Byte: 0001 << addr[1:0].
  - Half: 0011 << addr[1:0], so 0011 or 1100.
  - Word: 1111.
- Writedata rules:
  - Byte: op_wdata[7:0] replicated ×4.
  - Half: op_wdata[15:0] replicated ×2.
  - Word: op_wdata unchanged.
- Read extraction:
  - Byte: lane addr[1:0] selected.
  - Half: bits [15:0] when addr[1]=0, bits [31:16] when addr[1]=1.
  - Extension: sign-extend if op_signed=1, else zero-extend. Word loads are not extended.
- A start while busy=1 is ignored.
- read and write are never asserted together.

## Timing
- Reset values: busy=0, done=0, err=0, rdata=0, read=0, write=0, address=0, byteenable=0, writedata=0. State is IDLE.
- Start accepted at edge N:
  - read or write is high during cycle N+1.
  - With no stall, done is high in cycle N+2.
  - Latency is 2 + (number of waitrequest-high cycles).
- Misaligned request: done=1 and err=1 in cycle N+1. read and write stay 0 throughout.
- read and write drop in the cycle after the completing cycle; there are no back-to-back transfers without passing through FINISH.
- A new start may be accepted in the cycle after done, i.e. in IDLE.
- Reset low at any edge, including during ACCESS with waitrequest=1:
  - Next cycle read=0, write=0, busy=0, and state is IDLE.
  - done is not pulsed.
- rdata changes only on load completion or reset. Stores and errors leave rdata unchanged.

## Test plan
- LW from 0x64, readdata=0xAABBCCDD, waitrequest=0 -> address=0x64, byteenable=1111, read for 1 cycle, done 2 cycles after start, rdata=0xAABBCCDD, err=0.
- LB from 0x64 with op_signed=1, then LBU from 0x65 and LH from 0x66 signed, same readdata -> rdata = 0xFFFFFFDD, then 0x000000CC, then 0xFFFFAABB. byteenable = 0001, 0010, 1100 respectively.
- SB 0x12 to 0x1CB, then SH 0x3456 to 0x1CA:
  - SB -> address=0x1C8, byteenable=1000, writedata=0x12121212, write high 1 cycle.
  - SH -> byteenable=1100, writedata=0x34563456.
- LW at 0x100 with waitrequest high for 3 cycles -> read held 4 cycles with address and byteenable stable; done 5 cycles after start with the readdata present on the 4th read cycle.
- LW at 0x66 and LH at 0x65 -> no read ever asserted; done=1 and err=1 one cycle after start; rdata unchanged.
- Reset driven low during a 2-cycle waitrequest stall -> next cycle read=0, busy=0, no done. A following LW at 0x64 completes normally.

Source files
------------

// File: rtl/mips_bus_master.sv
// mips_bus_master: Avalon-MM initiator turning one CPU load/store into a single bus transfer.
// Misaligned or illegal-size requests complete with err and never reach the bus.
module mips_bus_master (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        op_write,
   input  logic [1:0]  op_size,
   input  logic        op_signed,
   input  logic [31:0] op_addr,
   input  logic [31:0] op_wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [3:0]  byteenable,
   output logic [31:0] writedata,
   input  logic        waitrequest,
   input  logic [31:0] readdata
);
   typedef enum logic [1:0] {IDLE, ACCESS, FINISH} state_t;
   state_t state_q, state_d;
   logic [31:0] address_q, address_d, writedata_q, writedata_d, rdata_q, rdata_d;
   logic [3:0] be_q, be_d;
   logic [1:0] size_q, size_d, off_q, off_d;
   logic write_q, write_d, err_q, err_d, signed_q, signed_d;
   logic misaligned;
   logic [7:0] rd_byte;
   logic [15:0] rd_half;
   logic [31:0] rd_ext;
   assign misaligned = (op_size == 2'b11) || (op_size == 2'b01 && op_addr[0]) ||
                       (op_size == 2'b10 && op_addr[1:0] != 2'b00);
   assign rd_byte = readdata[{off_q, 3'b000} +: 8];
   assign rd_half = off_q[1] ? readdata[31:16] : readdata[15:0];
   assign rd_ext = size_q == 2'b00 ? {{24{signed_q & rd_byte[7]}}, rd_byte} :
                   size_q == 2'b01 ? {{16{signed_q & rd_half[15]}}, rd_half} : readdata;
   always_comb begin
      state_d = state_q;
      address_d = address_q;
      writedata_d = writedata_q;
      rdata_d = rdata_q;
      be_d = be_q;
      size_d = size_q;
      off_d = off_q;
      write_d = write_q;
      err_d = err_q;
      signed_d = signed_q;
      case (state_q)
         IDLE: if (start) begin
            size_d = op_size;
            off_d = op_addr[1:0];
            signed_d = op_signed;
            write_d = op_write;
            err_d = misaligned;
            state_d = misaligned ? FINISH : ACCESS;
            if (!misaligned) begin
               address_d = {op_addr[31:2], 2'b00};
               be_d = op_size == 2'b00 ? 4'b0001 << op_addr[1:0] :
                      op_size == 2'b01 ? 4'b0011 << op_addr[1:0] : 4'b1111;
               writedata_d = op_size == 2'b00 ? {4{op_wdata[7:0]}} :
                             op_size == 2'b01 ? {2{op_wdata[15:0]}} : op_wdata;
            end
         end
         ACCESS: if (!waitrequest) begin
            state_d = FINISH;
            rdata_d = write_q ? rdata_q : rd_ext;
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         address_q <= '0;
         writedata_q <= '0;
         rdata_q <= '0;
         be_q <= '0;
         size_q <= '0;
         off_q <= '0;
         write_q <= 1'b0;
         err_q <= 1'b0;
         signed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         address_q <= address_d;
         writedata_q <= writedata_d;
         rdata_q <= rdata_d;
         be_q <= be_d;
         size_q <= size_d;
         off_q <= off_d;
         write_q <= write_d;
         err_q <= err_d;
         signed_q <= signed_d;
      end
   end
   assign busy = state_q != IDLE;
   assign done = state_q == FINISH;
   assign err = done & err_q;
   assign read = state_q == ACCESS && !write_q;
   assign write = state_q == ACCESS && write_q;
   assign rdata = rdata_q;
   assign address = address_q;
   assign byteenable = be_q;
   assign writedata = writedata_q;
endmodule

// File: tb/tb_mips_bus_master.sv
// tb_mips_bus_master: directed load/store/stall/misalign/reset vectors with hand-computed results.
module tb_mips_bus_master;
   logic clk = 1'b0, reset, start, op_write, op_signed, waitrequest;
   logic [1:0] op_size;
   logic [31:0] op_addr, op_wdata, readdata;
   logic busy, done, err, read, write;
   logic [31:0] rdata, address, writedata;
   logic [3:0] byteenable;
   int n_cmp = 0, n_err = 0;
   logic [31:0] last_rd;
   mips_bus_master dut (
      .clk(clk), .reset(reset), .start(start), .op_write(op_write), .op_size(op_size),
      .op_signed(op_signed), .op_addr(op_addr), .op_wdata(op_wdata), .busy(busy), .done(done),
      .err(err), .rdata(rdata), .address(address), .read(read), .write(write),
      .byteenable(byteenable), .writedata(writedata), .waitrequest(waitrequest), .readdata(readdata)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic issue(input logic wr, input logic [1:0] sz, input logic sgn, input logic [31:0] a, input logic [31:0] wd);
      start = 1'b1;
      op_write = wr;
      op_size = sz;
      op_signed = sgn;
      op_addr = a;
      op_wdata = wd;
      @(negedge clk);
      start = 1'b0;
   endtask
   task automatic xfer(input string tag, input logic wr, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd, input int stalls,
                       input logic [31:0] exp_addr, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                       input logic [31:0] exp_rd);
      issue(wr, sz, sgn, a, wd);
      for (int i = 0; i <= stalls; i++) begin
         waitrequest = i < stalls;
         readdata = i < stalls ? 32'hDEADBEEF : rd;
         check({tag, ".read"}, read, !wr);
         check({tag, ".write"}, write, wr);
         check({tag, ".busy"}, busy, 1);
         check({tag, ".done_early"}, done, 0);
         check({tag, ".addr"}, address, exp_addr);
         check({tag, ".be"}, byteenable, exp_be);
         if (wr) check({tag, ".wdata"}, writedata, exp_wd);
         @(negedge clk);
      end
      waitrequest = 1'b0;
      readdata = 32'h0;
      check({tag, ".done"}, done, 1);
      check({tag, ".err"}, err, 0);
      check({tag, ".rw_off"}, {read, write}, 0);
      check({tag, ".rdata"}, rdata, exp_rd);
      last_rd = exp_rd;
      @(negedge clk);
      check({tag, ".done_drop"}, done, 0);
      check({tag, ".idle"}, busy, 0);
   endtask
   task automatic bad(input string tag, input logic [1:0] sz, input logic [31:0] a);
      issue(1'b0, sz, 1'b0, a, 32'h0);
      check({tag, ".done"}, done, 1);
      check({tag, ".err"}, err, 1);
      check({tag, ".rw"}, {read, write}, 0);
      check({tag, ".rdata"}, rdata, last_rd);
      @(negedge clk);
      check({tag, ".done_drop"}, {done, err, busy, read}, 0);
   endtask
   initial begin
      reset = 1'b0;
      {start, op_write, op_signed, waitrequest} = '0;
      op_size = 2'b00;
      op_addr = '0;
      op_wdata = '0;
      readdata = '0;
      repeat (2) @(negedge clk);
      check("rst.ctl", {busy, done, err, read, write}, 0);
      check("rst.rdata", rdata, 0);
      check("rst.addr", address, 0);
      check("rst.be", byteenable, 0);
      check("rst.wdata", writedata, 0);
      reset = 1'b1;
      @(negedge clk);
      xfer("lw", 0, 2'b10, 0, 32'h64, 0, 32'hAABBCCDD, 0, 32'h64, 4'b1111, 0, 32'hAABBCCDD);
      xfer("lb", 0, 2'b00, 1, 32'h64, 0, 32'hAABBCCDD, 0, 32'h64, 4'b0001, 0, 32'hFFFFFFDD);
      xfer("lbu", 0, 2'b00, 0, 32'h65, 0, 32'hAABBCCDD, 0, 32'h64, 4'b0010, 0, 32'h000000CC);
      xfer("lh", 0, 2'b01, 1, 32'h66, 0, 32'hAABBCCDD, 0, 32'h64, 4'b1100, 0, 32'hFFFFAABB);
      xfer("sb", 1, 2'b00, 0, 32'h1CB, 32'hABCD0012, 0, 0, 32'h1C8, 4'b1000, 32'h12121212, 32'hFFFFAABB);
      xfer("sh", 1, 2'b01, 0, 32'h1CA, 32'h99993456, 0, 0, 32'h1C8, 4'b1100, 32'h34563456, 32'hFFFFAABB);
      xfer("lw_stall", 0, 2'b10, 0, 32'h100, 0, 32'h11223344, 3, 32'h100, 4'b1111, 0, 32'h11223344);
      xfer("lhu", 0, 2'b01, 0, 32'h64, 0, 32'h12348765, 1, 32'h64, 4'b0011, 0, 32'h00008765);
      xfer("lb_pos", 0, 2'b00, 1, 32'h67, 0, 32'h7F00FF00, 0, 32'h64, 4'b1000, 0, 32'h0000007F);
      xfer("sw", 1, 2'b10, 0, 32'h200, 32'hCAFEF00D, 0, 2, 32'h200, 4'b1111, 32'hCAFEF00D, 32'h0000007F);
      bad("mis_lw", 2'b10, 32'h66);
      bad("mis_lh", 2'b01, 32'h65);
      bad("mis_sz", 2'b11, 32'h64);
      issue(0, 2'b10, 0, 32'h100, 0);
      waitrequest = 1'b1;
      check("rst_stall.read1", read, 1);
      @(negedge clk);
      check("rst_stall.read2", read, 1);
      reset = 1'b0;
      @(negedge clk);
      check("rst_stall.after", {read, write, busy, done}, 0);
      reset = 1'b1;
      waitrequest = 1'b0;
      @(negedge clk);
      check("rst_stall.nodone", {done, busy}, 0);
      last_rd = 32'h0;
      xfer("lw_post", 0, 2'b10, 0, 32'h64, 0, 32'h55667788, 0, 32'h64, 4'b1111, 0, 32'h55667788);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
